// File: rtl/cnn_pkg.sv
// ----------------------------------------------------------------------------
// cnn_pkg
//  Shared configuration for the output collector: array geometry, datapath
//  widths, the collector FSM state type and the accumulator-to-output
//  saturation helper.
//  Contents:
//   NUM_COL, PSUM_WIDTH, ACC_WIDTH, OUT_WIDTH, ADDR_WIDTH, CNT_WIDTH
//   COL_WIDTH   index width for one column of a row
//   ROW_WIDTH   width of one saturated output row
//   collector_state_t  {IDLE, ACCUM, FLUSH}
//   sat_trunc()        clamp a signed accumulator to the signed output range
// ----------------------------------------------------------------------------
package cnn_pkg;

   localparam int NUM_COL    = 8;
   localparam int PSUM_WIDTH = 16;
   localparam int ACC_WIDTH  = 24;
   localparam int OUT_WIDTH  = 16;
   localparam int ADDR_WIDTH = 10;
   localparam int CNT_WIDTH  = 8;

   localparam int COL_WIDTH  = $clog2(NUM_COL);
   localparam int ROW_WIDTH  = NUM_COL * OUT_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      FLUSH
   } collector_state_t;

   // Output range expressed at accumulator width so the compares are signed
   // and width-matched; ~max is the most negative output value.
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   function automatic logic signed [OUT_WIDTH-1:0] sat_trunc(
      input logic signed [ACC_WIDTH-1:0] acc
   );
      if (acc > SAT_MAX) begin
         return SAT_MAX[OUT_WIDTH-1:0];
      end
      if (acc < SAT_MIN) begin
         return SAT_MIN[OUT_WIDTH-1:0];
      end
      return acc[OUT_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/output_collector_if.sv
// ----------------------------------------------------------------------------
// output_collector_if
//  Write port towards output memory. A word transfers on a rising edge where
//  out_we && out_ready.
//  Signals:
//   out_addr   word address
//   out_data   signed write data
//   out_we     write valid (collector -> memory)
//   out_ready  memory can accept a word (memory -> collector)
//  Modports: master = collector side, slave = memory side.
// ----------------------------------------------------------------------------
interface output_collector_if;
   import cnn_pkg::*;

   logic [ADDR_WIDTH-1:0] out_addr;
   logic [OUT_WIDTH-1:0]  out_data;
   logic                  out_we;
   logic                  out_ready;

   modport master (output out_addr, output out_data, output out_we, input out_ready);
   modport slave  (input out_addr, input out_data, input out_we, output out_ready);

endinterface

// File: rtl/row_fifo.sv
// ----------------------------------------------------------------------------
// row_fifo
//  Two-entry buffer of saturated output rows.
//  Ports:
//   clk, reset  clock, synchronous active-high reset
//   push, din   write a row; dropped when full unless popping in the same cycle
//   pop         release the head row (ignored when empty)
//   full, empty occupancy flags
//   head        oldest stored row
// ----------------------------------------------------------------------------
module row_fifo
   import cnn_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 push,
   input  logic [ROW_WIDTH-1:0] din,
   input  logic                 pop,
   output logic                 full,
   output logic                 empty,
   output logic [ROW_WIDTH-1:0] head
);

   logic [ROW_WIDTH-1:0] mem [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           count;
   logic                 push_ok;
   logic                 pop_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign head    = mem[rd_ptr];
   // A simultaneous pop frees the slot being written, so full does not block it.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   // NOTE: row storage is deliberately not reset; count/pointers alone define
   // validity, and leaving the array reset-free lets it map to plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/output_collector.sv
// ----------------------------------------------------------------------------
// output_collector
//  Accumulates per-column partial-sum rows on each sum_timestep, saturates
//  every completed row into a 2-row buffer and serialises buffered rows one
//  word per cycle to output memory. conv flushes any partial row; done pulses
//  once everything has been written.
//  Ports:
//   clk, reset    clock, synchronous active-high reset
//   enable        start (IDLE only); latches base_addr
//   num_accum     sum_timestep pulses per row (0 behaves as 1)
//   base_addr     first output address
//   sum_timestep  add psum_row into the accumulators (ACCUM only)
//   conv          end of convolution (ACCUM only)
//   psum_row      column c at [c*PSUM_WIDTH +: PSUM_WIDTH], signed
//   mem           output memory write port (output_collector_if.master)
//   busy          state != IDLE
//   done          one-cycle pulse when the flush completes
//   overflow      sticky: a row was dropped on a full buffer
//  Build option: define RELU_EN to write negative saturated words as 0.
// ----------------------------------------------------------------------------
module output_collector
   import cnn_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [CNT_WIDTH-1:0]          num_accum,
   input  logic [ADDR_WIDTH-1:0]         base_addr,
   input  logic                          sum_timestep,
   input  logic                          conv,
   input  logic [NUM_COL*PSUM_WIDTH-1:0] psum_row,
   output_collector_if.master            mem,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow
);

   localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(NUM_COL - 1);

   collector_state_t            state, state_nxt;
   logic signed [ACC_WIDTH-1:0] acc     [NUM_COL];
   logic signed [ACC_WIDTH-1:0] acc_sum [NUM_COL];
   logic signed [ACC_WIDTH-1:0] acc_nxt [NUM_COL];
   logic [CNT_WIDTH-1:0]        acc_cnt, cnt_nxt, cnt_inc, target;
   logic                        push;
   logic [ROW_WIDTH-1:0]        push_row;
   logic                        full, empty, pop, accept;
   logic [ROW_WIDTH-1:0]        head;
   logic [ADDR_WIDTH-1:0]       base_q, wr_cnt;
   logic [COL_WIDTH-1:0]        col_idx;
   logic signed [OUT_WIDTH-1:0] head_word;

   row_fifo u_row_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (push_row),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = acc_cnt;
      push      = 1'b0;
      push_row  = '0;
      done      = 1'b0;
      target    = (num_accum == '0) ? CNT_WIDTH'(1) : num_accum;
      cnt_inc   = acc_cnt + 1'b1;
      for (int c = 0; c < NUM_COL; c++) begin
         acc_nxt[c] = acc[c];
         acc_sum[c] = acc[c] + $signed({{(ACC_WIDTH - PSUM_WIDTH){psum_row[c*PSUM_WIDTH + PSUM_WIDTH - 1]}},
                                        psum_row[c*PSUM_WIDTH +: PSUM_WIDTH]});
      end

      case (state)
         IDLE: begin
            if (enable) state_nxt = ACCUM;
         end
         ACCUM: begin
            if (sum_timestep) begin
               if (cnt_inc == target) begin
                  push    = 1'b1;
                  cnt_nxt = '0;
                  for (int c = 0; c < NUM_COL; c++) begin
                     push_row[c*OUT_WIDTH +: OUT_WIDTH] = sat_trunc(acc_sum[c]);
                     acc_nxt[c] = '0;
                  end
               end else begin
                  acc_nxt = acc_sum;
                  cnt_nxt = cnt_inc;
               end
            end
            // The add above is committed on the same edge that enters FLUSH.
            if (conv) state_nxt = FLUSH;
         end
         FLUSH: begin
            // First FLUSH cycle pushes any partial row; clearing acc_cnt
            // guarantees it happens only once.
            if (acc_cnt != '0) begin
               push    = 1'b1;
               cnt_nxt = '0;
               for (int c = 0; c < NUM_COL; c++) begin
                  push_row[c*OUT_WIDTH +: OUT_WIDTH] = sat_trunc(acc[c]);
                  acc_nxt[c] = '0;
               end
            end else if (empty) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Writer: present the head row one column at a time.
   assign head_word    = head[col_idx*OUT_WIDTH +: OUT_WIDTH];
   assign accept       = !empty && mem.out_ready;
   assign pop          = accept && (col_idx == LAST_COL);
   assign mem.out_we   = !empty;
   assign mem.out_addr = base_q + wr_cnt;
`ifdef RELU_EN
   assign mem.out_data = (empty || head_word[OUT_WIDTH-1]) ? '0 : head_word;
`else
   assign mem.out_data = empty ? '0 : head_word;
`endif
   assign busy         = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         acc_cnt  <= '0;
         base_q   <= '0;
         wr_cnt   <= '0;
         col_idx  <= '0;
         overflow <= 1'b0;
         for (int c = 0; c < NUM_COL; c++) acc[c] <= '0;
      end else begin
         state   <= state_nxt;
         acc_cnt <= cnt_nxt;
         acc     <= acc_nxt;
         if (state == IDLE && enable) begin
            base_q   <= base_addr;
            wr_cnt   <= '0;
            overflow <= 1'b0;
         end else begin
            if (push && full && !pop) overflow <= 1'b1;
            if (accept) begin
               wr_cnt  <= wr_cnt + 1'b1;
               col_idx <= (col_idx == LAST_COL) ? '0 : col_idx + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_output_collector.sv
// ----------------------------------------------------------------------------
// tb_output_collector
//  Scoreboard bench for output_collector: stimulus tasks push the expected
//  (address, data) words into a queue; a negedge monitor pops and compares
//  every word the DUT transfers. Directed checks cover reset, latency,
//  saturation, overflow, stalls, address wrap, done timing and mid-run reset.
// ----------------------------------------------------------------------------
module tb_output_collector;
   import cnn_pkg::*;

   logic                          clk = 1'b0;
   logic                          reset = 1'b1;
   logic                          enable = 1'b0;
   logic [CNT_WIDTH-1:0]          num_accum = '0;
   logic [ADDR_WIDTH-1:0]         base_addr = '0;
   logic                          sum_timestep = 1'b0;
   logic                          conv = 1'b0;
   logic [NUM_COL*PSUM_WIDTH-1:0] psum_row = '0;
   logic                          busy, done, overflow;

   output_collector_if ifc ();

   output_collector dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .num_accum    (num_accum),
      .base_addr    (base_addr),
      .sum_timestep (sum_timestep),
      .conv         (conv),
      .psum_row     (psum_row),
      .mem          (ifc),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t sb_q[$];
   int  n_pass = 0;
   int  n_total = 0;
   int  cyc = 0;
   int  last_acc_cyc = 0;
   int  exp_addr = 0;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int relu(input int v);
`ifdef RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   always @(posedge clk) cyc++;

   // Monitor: every transferred word must match the head of the scoreboard.
   always @(negedge clk) begin
      wr_t e;
      if (!reset && ifc.out_we && ifc.out_ready) begin
         last_acc_cyc = cyc;
         if (sb_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("wr_addr", int'(ifc.out_addr), e.addr);
            check("wr_data", int'($signed(ifc.out_data)), e.data);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got time %0t expected finish before 500000", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      enable       = 1'b0;
      sum_timestep = 1'b0;
      conv         = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      sb_q.delete();
   endtask

   task automatic start(input int n, input int base);
      num_accum = CNT_WIDTH'(n);
      base_addr = ADDR_WIDTH'(base);
      exp_addr  = base;
      enable    = 1'b1;
      tick();
      enable    = 1'b0;
   endtask

   task automatic expect_row(input int vals[NUM_COL]);
      for (int c = 0; c < NUM_COL; c++) begin
         sb_q.push_back('{exp_addr % (1 << ADDR_WIDTH), relu(vals[c])});
         exp_addr++;
      end
   endtask

   task automatic expect_all(input int v);
      int r[NUM_COL];
      foreach (r[i]) r[i] = v;
      expect_row(r);
   endtask

   task automatic step_row(input int vals[NUM_COL]);
      for (int c = 0; c < NUM_COL; c++) psum_row[c*PSUM_WIDTH +: PSUM_WIDTH] = PSUM_WIDTH'(vals[c]);
      sum_timestep = 1'b1;
      tick();
      sum_timestep = 1'b0;
   endtask

   task automatic step_all(input int v);
      int r[NUM_COL];
      foreach (r[i]) r[i] = v;
      step_row(r);
   endtask

   task automatic do_conv();
      conv = 1'b1;
      tick();
      conv = 1'b0;
   endtask

   task automatic wait_done(input string tag, input bit timing);
      bit seen = 1'b0;
      int extra = 0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, int'(seen), 1);
      if (timing && seen) check({tag, "_done_cycle"}, cyc, last_acc_cyc + 1);
      repeat (3) begin
         @(negedge clk);
         if (done) extra++;
      end
      check({tag, "_done_once"}, extra, 0);
      check({tag, "_busy_after"}, int'(busy), 0);
      check({tag, "_sb_empty"}, sb_q.size(), 0);
   endtask

   initial begin
      int row_a[NUM_COL];
      int row_a_sat[NUM_COL];

      ifc.out_ready = 1'b1;
      do_reset();
      check("rst_we", int'(ifc.out_we), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_addr", int'(ifc.out_addr), 0);

      // 1: two timesteps (3 then 4) -> one row of 7s, first write next cycle.
      start(2, 100);
      check("t1_busy", int'(busy), 1);
      step_all(3);
      check("t1_no_write_yet", int'(ifc.out_we), 0);
      expect_all(7);
      step_all(4);
      check("t1_latency_we", int'(ifc.out_we), 1);
      check("t1_latency_addr", int'(ifc.out_addr), 100);

      // 2: saturation at both rails and just past them, doubled over 2 steps.
      row_a     = '{20000, -20000, 100, -100, 16384, -16384, 0, 1};
      row_a_sat = '{32767, -32768, 200, -200, 32767, -32768, 0, 2};
      expect_row(row_a_sat);
      step_row(row_a);
      step_row(row_a);
      do_conv();
      wait_done("t1t2", 1'b0);

      // 4: partial row flushed on conv; done the cycle after the last write.
      start(4, 400);
      expect_all(5);
      step_all(5);
      do_conv();
      wait_done("t4", 1'b1);

      // 3: stall with 3 rows pushed -> third dropped, outputs held steady.
      ifc.out_ready = 1'b0;
      start(1, 200);
      expect_all(1);
      step_all(1);
      expect_all(2);
      step_all(2);
      check("t3_full_no_drop", int'(overflow), 0);
      step_all(3);
      check("t3_overflow", int'(overflow), 1);
      for (int i = 0; i < 17; i++) begin
         tick();
         if (i % 8 == 0) begin
            check("t3_stall_we", int'(ifc.out_we), 1);
            check("t3_stall_addr", int'(ifc.out_addr), 200);
            check("t3_stall_data", int'($signed(ifc.out_data)), 1);
         end
      end
      ifc.out_ready = 1'b1;
      do_conv();
      wait_done("t3", 1'b0);

      // 5: address wrap; num_accum=0 behaves as 1.
      start(0, 1020);
      expect_all(9);
      step_all(9);
      do_conv();
      wait_done("t5", 1'b0);

      // 6: reset mid-drain abandons buffered rows, then a fresh run.
      ifc.out_ready = 1'b0;
      start(1, 50);
      expect_all(6);
      step_all(6);
      expect_all(7);
      step_all(7);
      step_all(8);
      check("t6_overflow", int'(overflow), 1);
      ifc.out_ready = 1'b1;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("t6_rst_we", int'(ifc.out_we), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_overflow", int'(overflow), 0);
      reset = 1'b0;
      sb_q.delete();
      start(1, 300);
      expect_all(-8);
      step_all(-8);
      check("t6_new_base", int'(ifc.out_addr), 300);
      do_conv();
      wait_done("t6", 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
